// File: rtl/rr_mux_sel.sv
//==============================================================================
// Module   : rr_mux_sel
// Purpose  : Registered N:1 channel multiplexer with round-robin arbitration,
//            an encoded select output and a one-slot valid/ready output stage.
//            Define RRMUX_FIXED_PRIO_EN to build a fixed lowest-index-first
//            priority arbiter in place of the round-robin arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_mux_sel #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  d,
    output logic [N-1:0]    ack,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [W-1:0]    Y,
    output logic [SW-1:0]   sel
);

    logic            valid_q, valid_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic            load;
    logic            found;
    logic [SW-1:0]   grant_idx;
    logic [N-1:0]    ack_w;

    // The slot may take a new word when empty or when it is being popped.
    assign load = !valid_q || out_ready;

`ifdef RRMUX_FIXED_PRIO_EN
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                grant_idx = SW'(k);
            end
        end
    end

    assign ptr_d = '0;
`else
    // Search starts at ptr and wraps at N, so non-power-of-two N never
    // visits a nonexistent channel.
    always_comb begin
        int           idx;
        logic [SW-1:0] idx_sw;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_sw    = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_sw = SW'(idx);
            if (!found && req[idx_sw]) begin
                found     = 1'b1;
                grant_idx = idx_sw;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load && found) begin
            if (grant_idx == SW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SW'(1);
            end
        end
    end
`endif

    always_comb begin
        ack_w = '0;
        if (load && found) begin
            ack_w[grant_idx] = 1'b1;
        end
    end

    assign ack = rst ? '0 : ack_w;

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                y_d   = d[int'(grant_idx)*W +: W];
                sel_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign Y         = y_q;
    assign sel       = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_sel.sv
//==============================================================================
// Module   : tb_rr_mux_sel
// Purpose  : Directed bench for rr_mux_sel (N=8, W=4, channel i carries i+3)
//            with a queue-based scoreboard checking every popped word.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_mux_sel;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  d;
    logic [N-1:0]    ack;
    logic            out_ready;
    logic            out_valid;
    logic [W-1:0]    Y;
    logic [SW-1:0]   sel;

    int vectors  = 0;
    int miscomps = 0;
    int exp_q[$];

    rr_mux_sel #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d         (d),
        .ack       (ack),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .Y         (Y),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscomps++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive req/out_ready, check ack and out_valid, and queue the
    // word expected from channel g (g<0 means no grant this cycle).
    task automatic cyc(input logic [N-1:0] r, input logic rdy, input int g, input int ev);
        logic [N-1:0] exp_ack;
        req       = r;
        out_ready = rdy;
        exp_ack   = (g < 0) ? '0 : (N'(1) << g);
        @(negedge clk);
        chk("ack", int'(ack), int'(exp_ack));
        chk("out_valid", int'(out_valid), ev);
        if (g >= 0) begin
            exp_q.push_back(g * 16 + (g + 3));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold_cyc(input int ey, input int es);
        req       = 8'hFF;
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_ack", int'(ack), 0);
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_Y", int'(Y), ey);
        chk("hold_sel", int'(sel), es);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_Y"}, int'(Y), 0);
        chk({tag, "_sel"}, int'(sel), 0);
    endtask

    // Scoreboard monitor: compares every word popped by the consumer.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscomps++;
                    $display("FAIL pop_unexpected: got sel=%0d Y=%0d, expected no word", sel, Y);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_sel", int'(sel), e / 16);
                    chk("pop_Y", int'(Y), e % 16);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        d         = {4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef RRMUX_FIXED_PRIO_EN
        cyc(8'h34, 1'b1, 2, 0);
        for (int i = 0; i < 4; i++) cyc(8'h34, 1'b1, 2, 1);
        cyc(8'h34, 1'b1, 2, 1);
        hold_cyc(5, 2);
        cyc(8'hFF, 1'b1, 0, 1);
        cyc(8'h00, 1'b1, -1, 1);
        cyc(8'h00, 1'b1, -1, 0);
`else
        // Full rotation with every channel requesting.
        cyc(8'hFF, 1'b1, 0, 0);
        for (int i = 1; i < 8; i++) cyc(8'hFF, 1'b1, i, 1);
        cyc(8'hFF, 1'b1, 0, 1);

        // Capture channel 5, stall, then release into channel 6.
        cyc(8'h20, 1'b1, 5, 1);
        for (int i = 0; i < 4; i++) hold_cyc(8, 5);
        cyc(8'hFF, 1'b1, 6, 1);

        // Sparse requests wrapping around the pointer.
        cyc(8'h02, 1'b1, 1, 1);
        cyc(8'h82, 1'b1, 7, 1);
        cyc(8'h82, 1'b1, 1, 1);
        cyc(8'h82, 1'b1, 7, 1);

        // Drain to empty, then a single requester.
        cyc(8'h00, 1'b1, -1, 1);
        cyc(8'h00, 1'b1, -1, 0);
        cyc(8'h04, 1'b1, 2, 0);
        cyc(8'h00, 1'b1, -1, 1);

        // Reset while a word is held discards it.
        cyc(8'hFF, 1'b1, 3, 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        chk_reset_state("midreset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(8'hFF, 1'b1, 0, 0);
        cyc(8'hFF, 1'b1, 1, 1);
        cyc(8'h00, 1'b1, -1, 1);
        cyc(8'h00, 1'b1, -1, 0);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_mux_sel.md
# rr_mux_sel

Parametrised, registered N:1 channel multiplexer with built-in round-robin arbitration and encoded select output. It is the sequential successor to the team's gate-level 8:1 multiplexer and 8:3 encoder. Each of N requesting channels presents a W-bit word. The block picks one requester per transfer, registers its word and index, and holds them under a valid/ready handshake toward the downstream consumer.

## Interface
- N, default 8: number of input channels; legal range 2..64, any value, not only powers of two.
- W, default 1: data width per channel in bits, ≥1.
- SW, default $clog2(N): select/index width. Derived only; never overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-channel request; bit i high means d slice i is valid.
- d  input  N*W  channel data; channel i occupies d[i*W +: W].
- ack  output  N  one-hot combinational pulse marking the channel whose word is captured this cycle.
- out_ready  input  1  downstream accepts Y/sel this cycle.
- out_valid  output  1  Y/sel hold a captured word.
- Y  output  W  registered data of the granted channel.
- sel  output  SW  registered index of the granted channel.

## Operation
- Output stage is one register slot, either EMPTY (out_valid=0) or FULL (out_valid=1).
- load = !out_valid || out_ready. The slot accepts a new word only when load is 1.
- When load=1 and req≠0, the arbiter picks channel g and asserts ack[g]=1 in that same cycle.
- At the next edge, in that case, the block sets Y ← d[g*W +: W], sel ← g and out_valid ← 1.
- When load=1 and req=0: ack=0; at the next edge out_valid ← 0. Y and sel keep their last values.
- When load=0 (FULL and !out_ready): ack=0. Y, sel and out_valid hold unchanged.
- Round-robin arbitration:
  - A pointer ptr (SW bits) marks the highest-priority channel.
  - The search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, and the first requesting channel wins.
  - After a grant to g, ptr ← g+1, wrapping to 0 when g=N-1; wrap is at N, not 2^SW.
  - ptr changes only on a grant.
- A channel that sees ack[i]=1 must drop req[i] or present its next word in the following cycle. The block does not mask requests itself.
- Reset values (asynchronous, immediate): out_valid=0, Y=0, sel=0, ptr=0, ack=0. ack is forced 0 while rst=1.
- Reset asserted mid-transfer discards the held word. No ack is issued during reset.

## Timing
- Request-to-output latency is 1 cycle: ack in cycle t, Y/sel/out_valid valid after edge t+1.
- Sustained throughput is one word per cycle while out_ready=1 and req≠0.
- A simultaneous pop and capture (FULL, out_ready=1, req≠0) replaces the word in the same edge without a bubble.
- Y and sel are stable for every cycle in which out_valid=1 and out_ready=0.
- ack is purely combinational from req, ptr, out_valid and out_ready. There is no combinational path from d to any output.

## Configuration
- RRMUX_FIXED_PRIO_EN:
  - Defined: the arbiter ignores ptr and always grants the lowest-index requesting channel, i.e. priority-encoder behaviour. ptr stays 0.
  - Undefined (default): round-robin as described under Operation.
  - Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: drive rst=1 mid-stream with req=8'hFF → out_valid=0, Y=0, sel=0, ack=0 immediately. After release, the first grant goes to channel 0.
- Round-robin, N=8, W=4, channel i data=i+3, req=8'hFF, out_ready=1 → sel sequence 0,1,…,7,0. Y=3,4,…,10,3 (4-bit). ack is one-hot each cycle.
- Sparse and wrap: req=8'b1000_0010 with ptr=2 → grant 7 (sel=7), then 1, then 7. No grant ever goes to a non-requesting channel.
- Backpressure: capture channel 5 (Y=8), then hold out_ready=0 for 4 cycles with req=8'hFF → Y=8 and sel=5 are stable and ack=0. Raising out_ready gives ack[6] in that cycle.
- Empty: out_ready=1, req=0 → out_valid drops to 0 the next cycle, then rises 1 cycle after req[2]=1 with sel=2.
- With RRMUX_FIXED_PRIO_EN, req=8'b0011_0100 held, out_ready=1 → sel=2 on every transfer.
